// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Quotient reported for divide-by-zero; sliced down to WIDTH (WIDTH <= 64).
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  // Granted-index width: $clog2(n), never below 1 bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/divider_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_select #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  // Walk the requesters starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    int          c;
    logic [IW-1:0] w_c;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    c     = 0;
    w_c   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      c   = (int'(i_ptr) + k) % N_REQ;
      w_c = IW'(c);
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one iterative divider among N_REQ requesters with round-robin
// arbitration, divide-by-zero short-circuit and a hang watchdog.
module divider_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [N_REQ-1:0]       req_valid_in,
  input  logic [N_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [N_REQ*WIDTH-1:0] req_divisor_in,
  output logic [N_REQ-1:0]       req_ready_out,
  output logic [N_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]       resp_quotient_out,
  output logic [WIDTH-1:0]       resp_remainder_out,
  output logic                   resp_error_out,
  output logic                   busy_out,
  output logic [WIDTH-1:0]       div_dividend_out,
  output logic [WIDTH-1:0]       div_divisor_out,
  output logic                   div_valid_out,
  input  logic [WIDTH-1:0]       div_quotient_in,
  input  logic [WIDTH-1:0]       div_remainder_in,
  input  logic                   div_done_in,
  input  logic                   div_error_in,
  input  logic                   div_busy_in
);

  localparam int IW = idx_w(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            r_state, w_state_nx;
  logic [IW-1:0]     r_ptr;
  logic [N_REQ-1:0]  r_goh;
  logic              r_div0;
  logic [TW-1:0]     r_timer;

  logic [N_REQ-1:0]  r_ready;
  logic [N_REQ-1:0]  r_resp_valid;
  logic [WIDTH-1:0]  r_quot, r_rem;
  logic              r_err;
  logic              r_busy;
  logic [WIDTH-1:0]  r_dvd, r_dvs;
  logic              r_div_valid;

  logic [N_REQ-1:0]  w_gnt;
  logic [IW-1:0]     w_idx, w_ptr_nx;
  logic              w_any;
  logic [WIDTH-1:0]  w_sel_dvd, w_sel_dvs;
  logic              w_sel_div0, w_timeout;
  logic              w_grant, w_issue, w_done, w_abort, w_div0_resp;

  rr_select #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .i_req (req_valid_in),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_sel_dvd  = req_dividend_in[int'(w_idx)*WIDTH +: WIDTH];
  assign w_sel_dvs  = req_divisor_in[int'(w_idx)*WIDTH +: WIDTH];
  assign w_sel_div0 = (w_sel_dvs == '0);
  assign w_timeout  = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_ptr_nx   = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Next-state and per-cycle action strobes.
  always_comb begin
    w_state_nx  = r_state;
    w_grant     = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_div0_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && !div_busy_in) begin
          w_grant    = 1'b1;
          w_state_nx = w_sel_div0 ? RESPOND : ISSUE;
        end
      end
      ISSUE: begin
        w_issue    = 1'b1;
        w_state_nx = WAIT;
      end
      WAIT: begin
        // A done arriving on the last watchdog cycle still wins.
        if (div_done_in) begin
          w_done     = 1'b1;
          w_state_nx = RESPOND;
        end else if (w_timeout) begin
          w_abort    = 1'b1;
          w_state_nx = RESPOND;
        end
      end
      RESPOND: begin
        // Divider results were already strobed on WAIT exit; only the
        // short-circuited divide-by-zero answer leaves from here.
        w_div0_resp = r_div0;
        w_state_nx  = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State register; busy mirrors the state it is registered with.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
    end
  end

  // Grant: pulse ready, capture operands/owner, advance the rr pointer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ready <= '0;
      r_goh   <= '0;
      r_ptr   <= '0;
      r_div0  <= 1'b0;
      r_dvd   <= '0;
      r_dvs   <= '0;
    end else begin
      r_ready <= '0;
      if (w_grant) begin
        r_ready <= w_gnt;
        r_goh   <= w_gnt;
        r_ptr   <= w_ptr_nx;
        r_div0  <= w_sel_div0;
        r_dvd   <= w_sel_dvd;
        r_dvs   <= w_sel_dvs;
      end
    end
  end

  // Issue pulse to the divider and the WAIT watchdog counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_div_valid <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_div_valid <= w_issue;
      if (w_issue)
        r_timer <= '0;
      else if (r_state == WAIT)
        r_timer <= r_timer + 1'b1;
    end
  end

  // Response bus: one-hot strobe, data held between strobes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_resp_valid <= '0;
      r_quot       <= '0;
      r_rem        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      if (w_done) begin
        r_resp_valid <= r_goh;
        r_quot       <= div_quotient_in;
        r_rem        <= div_remainder_in;
        r_err        <= div_error_in;
      end else if (w_abort) begin
        r_resp_valid <= r_goh;
        r_quot       <= '0;
        r_rem        <= '0;
        r_err        <= 1'b1;
      end else if (w_div0_resp) begin
        r_resp_valid <= r_goh;
        r_quot       <= DIV0_QUOTIENT[WIDTH-1:0];
        r_rem        <= r_dvd;
        r_err        <= 1'b1;
      end
    end
  end

  assign req_ready_out      = r_ready;
  assign resp_valid_out     = r_resp_valid;
  assign resp_quotient_out  = r_quot;
  assign resp_remainder_out = r_rem;
  assign resp_error_out     = r_err;
  assign busy_out           = r_busy;
  assign div_dividend_out   = r_dvd;
  assign div_divisor_out    = r_dvs;
  assign div_valid_out      = r_div_valid;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural divider stub.
module tb_divider_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] dvd, dvs;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_q, resp_r, div_dvd, div_dvs, div_q, div_r;
  logic        resp_err, busy, div_valid, div_done, div_err, div_busy;

  divider_arbiter #(.WIDTH(32), .N_REQ(2), .TIMEOUT_CYCLES(64)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_dividend_in(dvd), .req_divisor_in(dvs),
    .req_ready_out(req_ready), .resp_valid_out(resp_valid),
    .resp_quotient_out(resp_q), .resp_remainder_out(resp_r),
    .resp_error_out(resp_err), .busy_out(busy),
    .div_dividend_out(div_dvd), .div_divisor_out(div_dvs),
    .div_valid_out(div_valid), .div_quotient_in(div_q),
    .div_remainder_in(div_r), .div_done_in(div_done),
    .div_error_in(div_err), .div_busy_in(div_busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider stub: done appears st_lat cycles after the div_valid cycle.
  int          st_lat  = 5;
  logic        st_hang = 1'b0;
  logic        st_err  = 1'b0;
  int          st_cnt;
  logic        st_act;
  logic [31:0] st_a, st_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_done <= 1'b0; div_busy <= 1'b0; st_act <= 1'b0;
      div_q <= '0; div_r <= '0; div_err <= 1'b0; st_cnt <= 0;
      st_a <= '0; st_b <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_valid && !st_hang) begin
        st_act <= 1'b1; div_busy <= 1'b1; st_cnt <= st_lat - 2;
        st_a <= div_dvd; st_b <= div_dvs;
      end else if (st_act) begin
        if (st_cnt == 0) begin
          div_done <= 1'b1; div_q <= st_a / st_b; div_r <= st_a % st_b;
          div_err <= st_err; st_act <= 1'b0; div_busy <= 1'b0;
        end else st_cnt <= st_cnt - 1;
      end
    end
  end

  typedef struct { int cyc; logic [1:0] oh; logic [31:0] q, r; logic err; } resp_t;
  typedef struct {
    logic [1:0] vld; logic [31:0] a0, b0, a1, b1;
    logic [1:0] oh; logic [31:0] q, r; logic err; int lat; int dv;
  } vec_t;

  int         rdy_cyc[$];
  logic [1:0] rdy_oh[$];
  int         dv_cyc[$];
  resp_t      resp_log[$];
  logic       auto_drop = 1'b1;
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic resp_t rget(input int i);
    resp_t d = '{0, 2'b00, 32'd0, 32'd0, 1'b0};
    return (i < resp_log.size()) ? resp_log[i] : d;
  endfunction
  function automatic logic [1:0] oget(input int i);
    return (i < rdy_oh.size()) ? rdy_oh[i] : 2'b00;
  endfunction
  function automatic int cget(input int i);
    return (i < rdy_cyc.size()) ? rdy_cyc[i] : -1000;
  endfunction
  function automatic int dget(input int i);
    return (i < dv_cyc.size()) ? dv_cyc[i] : -1000;
  endfunction

  task automatic clear_logs();
    rdy_cyc.delete(); rdy_oh.delete(); dv_cyc.delete(); resp_log.delete();
  endtask

  // One clock; observe outputs on the falling edge and retire accepted requests.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (|req_ready) begin
      rdy_cyc.push_back(cyc); rdy_oh.push_back(req_ready);
      if (auto_drop) req_valid = req_valid & ~req_ready;
    end
    if (div_valid) dv_cyc.push_back(cyc);
    if (|resp_valid) resp_log.push_back('{cyc, resp_valid, resp_q, resp_r, resp_err});
  endtask

  task automatic wait_resp(input int n, input int bound, input string nm);
    int g = 0;
    while (resp_log.size() < n && g < bound) begin tick(); g++; end
    if (resp_log.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s: %0d responses seen, expected %0d", nm, resp_log.size(), n);
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    resp_t rs;
    clear_logs();
    dvd = {v.a1, v.a0}; dvs = {v.b1, v.b0}; req_valid = v.vld;
    wait_resp(1, 200, $sformatf("v%0d wait", i));
    tick();
    rs = rget(0);
    chk($sformatf("v%0d ready_cnt", i), rdy_oh.size(), 1);
    chk($sformatf("v%0d ready_oh", i), oget(0), v.oh);
    chk($sformatf("v%0d resp_oh", i), rs.oh, v.oh);
    chk($sformatf("v%0d quot", i), rs.q, v.q);
    chk($sformatf("v%0d rem", i), rs.r, v.r);
    chk($sformatf("v%0d err", i), rs.err, v.err);
    chk($sformatf("v%0d latency", i), rs.cyc - cget(0), v.lat);
    chk($sformatf("v%0d dv_cnt", i), dv_cyc.size(), v.dv);
    if (v.dv != 0) chk($sformatf("v%0d dv_lat", i), dget(0) - cget(0), 1);
    chk($sformatf("v%0d hold", i), {resp_valid, resp_q, resp_err}, {2'b00, v.q, v.err});
    repeat (2) tick();
  endtask

  vec_t vecs[7];
  resp_t rs;

  initial begin
    // {vld, a0, b0, a1, b1, oh, q, r, err, lat, dv}
    vecs[0] = '{2'b01, 32'd1000, 32'd7, 32'd0, 32'd1, 2'b01, 32'd142, 32'd6, 1'b0, 7, 1};
    vecs[1] = '{2'b10, 32'd0, 32'd1, 32'd55, 32'd0, 2'b10, 32'hFFFFFFFF, 32'd55, 1'b1, 1, 0};
    vecs[2] = '{2'b01, 32'd0, 32'd5, 32'd0, 32'd1, 2'b01, 32'd0, 32'd0, 1'b0, 7, 1};
    vecs[3] = '{2'b10, 32'd0, 32'd1, 32'd7, 32'd9, 2'b10, 32'd0, 32'd7, 1'b0, 7, 1};
    vecs[4] = '{2'b10, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd1, 2'b10, 32'hFFFFFFFF, 32'd0, 1'b0, 7, 1};
    vecs[5] = '{2'b01, 32'd0, 32'd0, 32'd0, 32'd1, 2'b01, 32'hFFFFFFFF, 32'd0, 1'b1, 1, 0};
    vecs[6] = '{2'b01, 32'd123456789, 32'd1000, 32'd0, 32'd1, 2'b01, 32'd123456, 32'd789, 1'b0, 7, 1};

    rst_n = 1'b0; req_valid = '0; dvd = '0; dvs = '0;
    repeat (2) tick();
    chk("rst_strobes", {req_ready, resp_valid, busy, div_valid}, '0);
    chk("rst_quot", resp_q, 0);
    chk("rst_rem", resp_r, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_div_ops", {div_dvd, div_dvs}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Both requesters held from reset: grants and responses alternate.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    clear_logs(); auto_drop = 1'b0; st_lat = 3;
    dvd = {32'd90, 32'd100}; dvs = {32'd9, 32'd10}; req_valid = 2'b11;
    begin
      int g = 0;
      while (resp_log.size() < 4 && g < 200) begin
        tick();
        if (rdy_oh.size() >= 4) req_valid = '0;
        g++;
      end
    end
    if (resp_log.size() < 4) begin
      n_tests++; n_fail++; $display("FAIL alt wait: %0d responses, expected 4", resp_log.size());
    end
    chk("alt ready_cnt", rdy_oh.size(), 4);
    for (int i = 0; i < 4; i++) begin
      rs = rget(i);
      chk($sformatf("alt%0d ready_oh", i), oget(i), (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("alt%0d resp_oh", i), rs.oh, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("alt%0d q_r_err", i), {rs.q, rs.r, rs.err}, {32'd10, 32'd0, 1'b0});
    end
    auto_drop = 1'b1; st_lat = 5;
    repeat (3) tick();

    // Hung divider: watchdog fires 64 cycles after the issue pulse, then req1 runs.
    clear_logs(); st_hang = 1'b1;
    dvd = {32'd8, 32'd5}; dvs = {32'd2, 32'd1}; req_valid = 2'b11;
    begin
      int g = 0;
      while (resp_log.size() < 2 && g < 300) begin
        tick();
        if (resp_log.size() >= 1) st_hang = 1'b0;
        g++;
      end
    end
    st_hang = 1'b0;
    if (resp_log.size() < 2) begin
      n_tests++; n_fail++; $display("FAIL to wait: %0d responses, expected 2", resp_log.size());
    end
    rs = rget(0);
    chk("to0 resp_oh", rs.oh, 2'b01);
    chk("to0 q_r_err", {rs.q, rs.r, rs.err}, {32'd0, 32'd0, 1'b1});
    chk("to0 cycles", rs.cyc - dget(0), 64);
    rs = rget(1);
    chk("to1 resp_oh", rs.oh, 2'b10);
    chk("to1 q_r_err", {rs.q, rs.r, rs.err}, {32'd4, 32'd0, 1'b0});
    repeat (3) tick();

    // Divider reports error: flagged, and the pointer still moves past req0.
    clear_logs(); st_err = 1'b1;
    dvd = {32'd0, 32'd20}; dvs = {32'd1, 32'd3}; req_valid = 2'b01;
    wait_resp(1, 100, "derr wait");
    rs = rget(0);
    chk("derr resp_oh", rs.oh, 2'b01);
    chk("derr err", rs.err, 1'b1);
    st_err = 1'b0; repeat (2) tick();
    clear_logs();
    dvd = {32'd9, 32'd4}; dvs = {32'd3, 32'd2}; req_valid = 2'b11;
    wait_resp(2, 100, "rr wait");
    chk("rr first_grant", oget(0), 2'b10);
    chk("rr second_grant", oget(1), 2'b01);
    chk("rr q0", rget(0).q, 32'd3);
    chk("rr q1", rget(1).q, 32'd2);
    repeat (3) tick();

    // Reset in WAIT: outputs clear at once, the aborted op never responds.
    clear_logs(); st_lat = 20;
    dvd = {32'd0, 32'd50}; dvs = {32'd1, 32'd5}; req_valid = 2'b01;
    begin
      int g = 0;
      while (dv_cyc.size() < 1 && g < 50) begin tick(); g++; end
    end
    chk("mid issued", dv_cyc.size(), 1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 chk("mid async_clear", {req_ready, resp_valid, busy, div_valid, resp_q, resp_err, div_dvd}, '0);
    req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (30) tick();
    chk("mid no_resp", resp_log.size(), 0);
    st_lat = 5;
    dvd = {32'd0, 32'd81}; dvs = {32'd1, 32'd9}; req_valid = 2'b01;
    wait_resp(1, 100, "post_rst wait");
    rs = rget(0);
    chk("post_rst resp_oh", rs.oh, 2'b01);
    chk("post_rst q_r_err", {rs.q, rs.r, rs.err}, {32'd9, 32'd0, 1'b0});
    chk("post_rst latency", rs.cyc - cget(0), 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one iterative `divider` instance (WIDTH-bit, valid/busy/done/error interface) among N_REQ requesters, e.g. the x and y channels of the centroid pipeline.
- Round-robin arbitration with a per-requester valid/ready request handshake.
- Results return on a shared response bus with a one-hot valid.
- Divide-by-zero is short-circuited without using the divider; a watchdog aborts hung operations.

Parameters:
- WIDTH, 32, operand/result width; must match the attached divider.
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before abort; must be > divider latency.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; one clock; reset is asynchronous and active-low
- req_valid_in  input  N_REQ  per-requester request; held until accepted
- req_dividend_in  input  N_REQ*WIDTH  packed dividends; slice i belongs to requester i
- req_divisor_in  input  N_REQ*WIDTH  packed divisors
- req_ready_out  output  N_REQ  one-hot, 1-cycle accept pulse; operands captured this cycle
- resp_valid_out  output  N_REQ  one-hot, 1-cycle result strobe
- resp_quotient_out  output  WIDTH  shared quotient
- resp_remainder_out  output  WIDTH  shared remainder
- resp_error_out  output  1  qualifies resp_valid_out: divide-by-zero, divider error, or timeout
- busy_out  output  1  high whenever state != IDLE
- div_dividend_out  output  WIDTH  to divider dividend_in
- div_divisor_out  output  WIDTH  to divider divisor_in
- div_valid_out  output  1  to divider data_valid_in; 1-cycle pulse
- div_quotient_in  input  WIDTH  from divider
- div_remainder_in  input  WIDTH  from divider
- div_done_in  input  1  from divider data_valid_out
- div_error_in  input  1  from divider error_out
- div_busy_in  input  1  from divider busy_out

Behaviour:
- Reset: every output 0, state IDLE, rr pointer 0, timer 0.
  - Reset applies immediately and asynchronously, including mid-operation.
  - An in-flight result is discarded; no resp_valid is issued for it.
- All outputs are registered.
- Arbitration:
  - Candidates are the requesters with req_valid_in high.
  - Search starts at the rr pointer and wraps modulo N_REQ.
  - After a grant to i, the pointer becomes (i+1) mod N_REQ.
- States:
  - IDLE:
    - If any valid and div_busy_in == 0: grant winner g.
    - Pulse req_ready_out[g] and latch the operands and g.
    - If divisor == 0: go to RESPOND with error=1, quotient=all-ones, remainder=dividend.
    - Otherwise go to ISSUE.
  - ISSUE: div_valid_out=1 for exactly this cycle, operands held stable; clear timer; go to WAIT.
  - WAIT:
    - Increment timer each cycle.
    - On div_done_in: latch quotient, remainder and div_error_in; go to RESPOND.
    - Else if timer == TIMEOUT_CYCLES-1: error=1, quotient=0, remainder=0; go to RESPOND.
    - If done and timeout occur in the same cycle, done wins.
  - RESPOND: resp_valid_out[g]=1 with data for one cycle; go to IDLE.
- Latency:
  - Accept at cycle T → div_valid_out at T+1.
  - Divider done at cycle D → resp_valid_out at D+1.
  - Divide-by-zero: accept at T → resp_valid_out at T+1.
  - Minimum back-to-back: the next grant is possible in the cycle after RESPOND.
- Dropping req_valid_in before acceptance is legal; the request is simply not granted.
- Requesters must not change operands while req_valid_in is high and unaccepted.
- div_done_in outside WAIT is ignored.
- The response bus holds its last value while resp_valid_out == 0.

Decomposition:
- Package `div_arb_pkg`:
  - state enum {IDLE, ISSUE, WAIT, RESPOND}.
  - Granted-index width constant $clog2(N_REQ) (min 1).
  - DIV0_QUOTIENT constant (all-ones).
- Sub-module `rr_select`: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Instantiated once.

Test Plan:
- N_REQ=2, req0 = 1000/7 alone, stub divider latency 5 → ready0 at T; div_valid at T+1; resp_valid=2'b01, q=142, r=6, err=0, exactly 5+2 cycles after T.
- Both request continuously from reset (req0 100/10, req1 90/9) → grants alternate 0,1,0,1 and responses alternate; each result is correct (10, 10).
- req1 = 55/0 → resp_valid=2'b10 at T+1, err=1, q=32'hFFFFFFFF, r=55; div_valid_out never asserted.
- Divider stub never asserts done, TIMEOUT_CYCLES=64 → resp err=1 with q=0, exactly 64 cycles after ISSUE; the next queued request is then serviced.
- Stub asserts done and error (div_error_in=1) → resp err=1, and the rr pointer still advances.
- rst_n_in low during WAIT → outputs 0 asynchronously; no response for the aborted op; a fresh request after release completes normally.
